vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 44 ++++
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the helpers that derive the
// horizontal and vertical totals from them.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CW       = 12;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N counter for one display axis; wrap_o flags the enabled cycle
// on which the count returns from MODULUS-1 to zero.
module vga_axis_counter #(
  parameter int CW      = 12,
  parameter int MODULUS = 800
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // wrap_o is left combinational so the next axis can chain off it in the same cycle
  assign wrap_o  = en_i && (count_q == LAST);
  assign count_o = count_q;

  // Next count: hold, wrap to zero, or step by one
  always_comb begin
    count_d = count_q;
    if (!en_i) begin
      count_d = count_q;
    end else if (wrap_o) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/active-region timing generator with registered outputs.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          video_active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_cw_too_small
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  // One extra bit so region bounds equal to 2^CW still compare correctly
  localparam logic [CW:0] HA_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VA_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        H_ON   = 1'(HSYNC_POL);
  localparam logic        V_ON   = 1'(VSYNC_POL);

  logic [CW-1:0] hcount_s, vcount_s;
  logic          h_wrap_s, v_wrap_s, v_en_s;

  vga_axis_counter #(.CW(CW), .MODULUS(H_TOTAL)) u_hcnt (
    .clk_i(clk), .rst_ni(rst), .en_i(pix_ce), .count_o(hcount_s), .wrap_o(h_wrap_s)
  );

  assign v_en_s = pix_ce && h_wrap_s;

  vga_axis_counter #(.CW(CW), .MODULUS(V_TOTAL)) u_vcnt (
    .clk_i(clk), .rst_ni(rst), .en_i(v_en_s), .count_o(vcount_s), .wrap_o(v_wrap_s)
  );

  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          active_q, active_d, ls_q, ls_d, fs_q, fs_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;

  // Decode the current counter position into next output values
  always_comb begin
    active_d = ({1'b0, hcount_s} < HA_END) && ({1'b0, vcount_s} < VA_END);
    x_d      = {CW{1'b0}};
    y_d      = {CW{1'b0}};
    if (active_d) begin
      x_d = hcount_s;
      y_d = vcount_s;
    end else begin
      x_d = {CW{1'b0}};
      y_d = {CW{1'b0}};
    end
    hsync_d = (({1'b0, hcount_s} >= HS_BEG) && ({1'b0, hcount_s} < HS_END)) ? H_ON : ~H_ON;
    vsync_d = (({1'b0, vcount_s} >= VS_BEG) && ({1'b0, vcount_s} < VS_END)) ? V_ON : ~V_ON;
    ls_d    = (hcount_s == {CW{1'b0}});
    fs_d    = ls_d && (vcount_s == {CW{1'b0}});
  end

  // Output registers, advanced only on pixel-enable cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q  <= ~H_ON;
      vsync_q  <= ~V_ON;
      active_q <= 1'b0;
      x_q      <= {CW{1'b0}};
      y_q      <= {CW{1'b0}};
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else if (pix_ce) begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_active = active_q;
  assign x            = x_q;
  assign y            = y_q;
  assign line_start   = ls_q;
  assign frame_start  = fs_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Count completed frames, wrapping naturally at 8 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 8'd0;
    end else if (v_wrap_s) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
